// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one single-port multiplier among NumHosts bus hosts.
// Optional response watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction in flight, a request may be issued
// BUSY  | one transaction in flight, waiting for dev_rvalid_i (or watchdog)
module mult_arbiter #(
  parameter int unsigned NumHosts      = 2,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumHosts-1:0]              host_req_i,
  output logic [NumHosts-1:0]              host_gnt_o,
  input  logic [NumHosts*AddressWidth-1:0] host_addr_i,
  input  logic [NumHosts-1:0]              host_we_i,
  input  logic [NumHosts*DataWidth/8-1:0]  host_be_i,
  input  logic [NumHosts*DataWidth-1:0]    host_wdata_i,
  output logic [NumHosts-1:0]              host_rvalid_o,
  output logic [NumHosts*DataWidth-1:0]    host_rdata_o,
  output logic [NumHosts-1:0]              host_err_o,
  output logic                             dev_req_o,
  output logic [AddressWidth-1:0]          dev_addr_o,
  output logic                             dev_we_o,
  output logic [DataWidth/8-1:0]           dev_be_o,
  output logic [DataWidth-1:0]             dev_wdata_o,
  input  logic                             dev_rvalid_i,
  input  logic [DataWidth-1:0]             dev_rdata_i,
  input  logic                             dev_err_i
);

  localparam int unsigned PtrW = $clog2(NumHosts);
  localparam int unsigned BeW  = DataWidth / 8;

  if (NumHosts < 2) begin : g_bad_hosts
    $error("mult_arbiter: NumHosts must be at least 2");
  end
  if (DataWidth != 32) begin : g_bad_width
    $error("mult_arbiter: DataWidth must be 32");
  end
  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("mult_arbiter: TimeoutCycles must be at least 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] owner_q, owner_d;

  logic [NumHosts-1:0][AddressWidth-1:0] addr_arr;
  logic [NumHosts-1:0][BeW-1:0]          be_arr;
  logic [NumHosts-1:0][DataWidth-1:0]    wdata_arr;

  assign addr_arr  = host_addr_i;
  assign be_arr    = host_be_i;
  assign wdata_arr = host_wdata_i;

  logic [PtrW-1:0] winner;
  logic            found;
  logic [PtrW:0]   scan_sum;
  logic [PtrW-1:0] scan_idx;
  logic            can_issue;
  logic            issue;
  logic            timeout;
  logic            resp_fire;
  logic [DataWidth-1:0] resp_data;
  logic                 resp_err;

  // First requester at or after ptr, wrapping modulo NumHosts.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 0; i < NumHosts; i++) begin
      scan_sum = {1'b0, ptr_q} + (PtrW+1)'(i);
      if (scan_sum >= (PtrW+1)'(NumHosts)) begin
        scan_sum = scan_sum - (PtrW+1)'(NumHosts);
      end
      scan_idx = scan_sum[PtrW-1:0];
      if (!found && host_req_i[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Reset gates the combinational outputs so everything reads 0 while rst_ni is low.
  assign can_issue = (state_q == IDLE) || ((state_q == BUSY) && dev_rvalid_i);
  assign issue     = rst_ni && can_issue && found;
  assign resp_fire = rst_ni && (state_q == BUSY) && (dev_rvalid_i || timeout);
  assign resp_data = timeout ? '0 : dev_rdata_i;
  assign resp_err  = timeout ? 1'b1 : dev_err_i;

  assign dev_req_o   = issue;
  assign dev_addr_o  = issue ? addr_arr[winner]  : '0;
  assign dev_we_o    = issue ? host_we_i[winner] : 1'b0;
  assign dev_be_o    = issue ? be_arr[winner]    : '0;
  assign dev_wdata_o = issue ? wdata_arr[winner] : '0;

  // Responses follow the registered owner, never the winner of this cycle.
  for (genvar g = 0; g < NumHosts; g++) begin : g_host
    assign host_gnt_o[g]    = issue && (winner == PtrW'(g));
    assign host_rvalid_o[g] = resp_fire && (owner_q == PtrW'(g));
    assign host_err_o[g]    = host_rvalid_o[g] && resp_err;
    assign host_rdata_o[g*DataWidth +: DataWidth] = host_rvalid_o[g] ? resp_data : '0;
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (issue) begin
      cnt_d = '0;
    end else if ((state_q == BUSY) && !dev_rvalid_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign timeout = rst_ni && (state_q == BUSY) && !dev_rvalid_i &&
                   (cnt_q == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (issue) begin
      state_d = BUSY;
      owner_d = winner;
      ptr_d   = (winner == PtrW'(NumHosts - 1)) ? '0 : winner + PtrW'(1);
    end else if (resp_fire) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed vector bench for mult_arbiter (2 hosts, TimeoutCycles=4).
// Build with +define+MULT_ARB_TIMEOUT_EN to exercise the watchdog path.
module tb_mult_arbiter;

  localparam logic [31:0] AddrMul = 32'h0004_0000;
  localparam logic [31:0] AddrBad = 32'h0004_0004;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  host_req_i;
  logic [1:0]  host_gnt_o;
  logic [63:0] host_addr_i;
  logic [1:0]  host_we_i;
  logic [7:0]  host_be_i;
  logic [63:0] host_wdata_i;
  logic [1:0]  host_rvalid_o;
  logic [63:0] host_rdata_o;
  logic [1:0]  host_err_o;
  logic        dev_req_o;
  logic [31:0] dev_addr_o;
  logic        dev_we_o;
  logic [3:0]  dev_be_o;
  logic [31:0] dev_wdata_o;
  logic        dev_rvalid_i;
  logic [31:0] dev_rdata_i;
  logic        dev_err_i;

  int nerr = 0;
  int nchk = 0;

  mult_arbiter #(
    .NumHosts(2), .DataWidth(32), .AddressWidth(32), .TimeoutCycles(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
    .host_addr_i(host_addr_i), .host_we_i(host_we_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_addr_o(dev_addr_o), .dev_we_o(dev_we_o),
    .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0, a1, wd0, wd1;
    logic        dv;
    logic [31:0] drd;
    logic        derr;
    logic [1:0]  e_gnt;
    logic [31:0] e_daddr, e_dwdata;
    logic [1:0]  e_rv;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [1:0] req, we, input logic [31:0] a0, a1, wd0, wd1,
    input logic dv, input logic [31:0] drd, input logic derr,
    input logic [1:0] egnt, input logic [31:0] eda, edw,
    input logic [1:0] erv, input logic [31:0] er0, er1, input logic [1:0] eerr);
    vec_t v;
    v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1;
    v.dv = dv; v.drd = drd; v.derr = derr;
    v.e_gnt = egnt; v.e_daddr = eda; v.e_dwdata = edw;
    v.e_rv = erv; v.e_rd0 = er0; v.e_rd1 = er1; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [1:0] req, we, input logic [31:0] a0, a1, wd0, wd1,
                     input logic dv, input logic [31:0] drd, input logic derr);
    @(posedge clk_i);
    #1;
    host_req_i   = req;
    host_we_i    = we;
    host_addr_i  = {a1, a0};
    host_wdata_i = {wd1, wd0};
    dev_rvalid_i = dv;
    dev_rdata_i  = drd;
    dev_err_i    = derr;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    logic [3:0] e_be;
    logic       e_we;
    e_be = (v.e_gnt == 2'b01) ? 4'hF : (v.e_gnt == 2'b10) ? 4'h3 : 4'h0;
    e_we = v.e_gnt[0] ? v.we[0] : (v.e_gnt[1] ? v.we[1] : 1'b0);
    chk({tag, " gnt"},    32'(host_gnt_o),    32'(v.e_gnt));
    chk({tag, " dreq"},   32'(dev_req_o),     32'(|v.e_gnt));
    chk({tag, " daddr"},  dev_addr_o,         v.e_daddr);
    chk({tag, " dwdata"}, dev_wdata_o,        v.e_dwdata);
    chk({tag, " dwe"},    32'(dev_we_o),      32'(e_we));
    chk({tag, " dbe"},    32'(dev_be_o),      32'(e_be));
    chk({tag, " rvalid"}, 32'(host_rvalid_o), 32'(v.e_rv));
    chk({tag, " rdata0"}, host_rdata_o[31:0], v.e_rd0);
    chk({tag, " rdata1"}, host_rdata_o[63:32], v.e_rd1);
    chk({tag, " err"},    32'(host_err_o),    32'(v.e_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(2'b00,2'b00,0,0,0,0, 0,0,0, 2'b00,0,0, 2'b00,0,0,2'b00));
    vecs.push_back(mk(2'b01,2'b01,AddrMul,0,32'h0003_0005,0, 0,0,0,
                      2'b01,AddrMul,32'h0003_0005, 2'b00,0,0,2'b00));
    vecs.push_back(mk(2'b00,2'b00,0,0,0,0, 1,0,0, 2'b00,0,0, 2'b01,0,0,2'b00));
    vecs.push_back(mk(2'b01,2'b00,AddrMul,0,0,0, 0,0,0, 2'b01,AddrMul,0, 2'b00,0,0,2'b00));
    vecs.push_back(mk(2'b00,2'b00,0,0,0,0, 1,32'hF,0, 2'b00,0,0, 2'b01,32'hF,0,2'b00));
    vecs.push_back(mk(2'b11,2'b11,AddrMul,AddrMul,32'h11,32'h22, 0,0,0,
                      2'b10,AddrMul,32'h22, 2'b00,0,0,2'b00));
    vecs.push_back(mk(2'b11,2'b11,AddrMul,AddrMul,32'h11,32'h22, 1,32'hA1,0,
                      2'b01,AddrMul,32'h11, 2'b10,0,32'hA1,2'b00));
    vecs.push_back(mk(2'b11,2'b11,AddrMul,AddrMul,32'h11,32'h22, 1,32'hB0,0,
                      2'b10,AddrMul,32'h22, 2'b01,32'hB0,0,2'b00));
    vecs.push_back(mk(2'b11,2'b11,AddrMul,AddrMul,32'h11,32'h22, 1,32'hC1,0,
                      2'b01,AddrMul,32'h11, 2'b10,0,32'hC1,2'b00));
    vecs.push_back(mk(2'b00,2'b00,0,0,0,0, 1,32'hD0,0, 2'b00,0,0, 2'b01,32'hD0,0,2'b00));
    vecs.push_back(mk(2'b10,2'b00,0,AddrBad,0,0, 0,0,0, 2'b10,AddrBad,0, 2'b00,0,0,2'b00));
    vecs.push_back(mk(2'b00,2'b00,0,0,0,0, 1,0,1, 2'b00,0,0, 2'b10,0,0,2'b10));
    vecs.push_back(mk(2'b00,2'b00,0,0,0,0, 1,32'hDEAD_BEEF,1, 2'b00,0,0, 2'b00,0,0,2'b00));
    vecs.push_back(mk(2'b01,2'b00,AddrMul,0,0,0, 0,0,0, 2'b01,AddrMul,0, 2'b00,0,0,2'b00));
    vecs.push_back(mk(2'b01,2'b00,AddrMul,0,0,0, 1,32'h5,0, 2'b01,AddrMul,0, 2'b01,32'h5,0,2'b00));
    vecs.push_back(mk(2'b00,2'b00,0,0,0,0, 1,32'h6,0, 2'b00,0,0, 2'b01,32'h6,0,2'b00));
    vecs.push_back(mk(2'b00,2'b00,0,0,0,0, 0,0,0, 2'b00,0,0, 2'b00,0,0,2'b00));
    vecs.push_back(mk(2'b10,2'b00,0,AddrBad,0,0, 0,0,0, 2'b10,AddrBad,0, 2'b00,0,0,2'b00));
    vecs.push_back(mk(2'b01,2'b00,AddrMul,0,0,0, 0,0,0, 2'b00,0,0, 2'b00,0,0,2'b00));
    vecs.push_back(mk(2'b01,2'b00,AddrMul,0,0,0, 1,32'h7,0, 2'b01,AddrMul,0, 2'b10,0,32'h7,2'b00));
    vecs.push_back(mk(2'b00,2'b00,0,0,0,0, 1,32'h8,0, 2'b00,0,0, 2'b01,32'h8,0,2'b00));

    rst_ni       = 1'b0;
    host_req_i   = '0;
    host_we_i    = '0;
    host_addr_i  = '0;
    host_be_i    = {4'h3, 4'hF};
    host_wdata_i = '0;
    dev_rvalid_i = 1'b0;
    dev_rdata_i  = '0;
    dev_err_i    = 1'b0;
    #3;
    chk("reset gnt",    32'(host_gnt_o),    32'h0);
    chk("reset rvalid", 32'(host_rvalid_o), 32'h0);
    chk("reset dreq",   32'(dev_req_o),     32'h0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    foreach (vecs[i]) begin
      drv(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].wd0, vecs[i].wd1,
          vecs[i].dv, vecs[i].drd, vecs[i].derr);
      @(negedge clk_i);
      check_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while a transaction from host1 is in flight.
    drv(2'b10, 2'b00, 0, AddrBad, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("rb issue gnt", 32'(host_gnt_o), 32'h2);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    host_req_i = 2'b11;
    host_addr_i = {AddrMul, AddrMul};
    dev_rvalid_i = 1'b1;
    dev_rdata_i = 32'h55;
    #1;
    chk("rb gnt",    32'(host_gnt_o),    32'h0);
    chk("rb rvalid", 32'(host_rvalid_o), 32'h0);
    chk("rb dreq",   32'(dev_req_o),     32'h0);
    chk("rb rdata1", host_rdata_o[63:32], 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    host_req_i = 2'b00;
    dev_rdata_i = 32'h99;
    @(negedge clk_i);
    chk("rb late rvalid", 32'(host_rvalid_o), 32'h0);
    drv(2'b11, 2'b00, AddrMul, AddrMul, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("rb first gnt", 32'(host_gnt_o), 32'h1);
    drv(2'b00, 2'b00, 0, 0, 0, 0, 1, 32'h12, 0);
    @(negedge clk_i);
    chk("rb resp rvalid", 32'(host_rvalid_o), 32'h1);
    chk("rb resp rdata0", host_rdata_o[31:0], 32'h12);

    // Device never answers a request from host1.
    drv(2'b10, 2'b00, 0, AddrMul, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("to issue gnt", 32'(host_gnt_o), 32'h2);
`ifdef MULT_ARB_TIMEOUT_EN
    for (int k = 1; k <= 4; k++) begin
      drv(2'b01, 2'b00, AddrMul, 0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      chk($sformatf("to c%0d gnt", k), 32'(host_gnt_o), 32'h0);
      chk($sformatf("to c%0d rvalid", k), 32'(host_rvalid_o), (k == 4) ? 32'h2 : 32'h0);
      chk($sformatf("to c%0d err", k), 32'(host_err_o), (k == 4) ? 32'h2 : 32'h0);
      chk($sformatf("to c%0d rdata1", k), host_rdata_o[63:32], 32'h0);
    end
    drv(2'b00, 2'b00, 0, 0, 0, 0, 1, 32'h77, 0);
    @(negedge clk_i);
    chk("to late rvalid", 32'(host_rvalid_o), 32'h0);
`else
    for (int k = 1; k <= 6; k++) begin
      drv(2'b01, 2'b00, AddrMul, 0, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      chk($sformatf("nto c%0d gnt", k), 32'(host_gnt_o), 32'h0);
      chk($sformatf("nto c%0d dreq", k), 32'(dev_req_o), 32'h0);
      chk($sformatf("nto c%0d rvalid", k), 32'(host_rvalid_o), 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
